// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction-fetch front end,
// control and the pipeline chains.
//   ROM_AWIDTH_DEF - default ROM word-address / PC width
//   IWIDTH_DEF     - default instruction width
//   RESET_PC_DEF   - PC loaded on reset
//   fetch_entry_t  - prefetch queue entry layout {pc, instr}
package fetch_unit_pkg;
  localparam int ROM_AWIDTH_DEF = 8;
  localparam int IWIDTH_DEF     = 16;
  localparam int RESET_PC_DEF   = 0;

  typedef struct packed {
    logic [ROM_AWIDTH_DEF-1:0] pc;
    logic [IWIDTH_DEF-1:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of prefetched {pc, instr} entries.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push/data  - write push_data at the tail
//   pop        - drop the head entry
//   flush      - discard all entries (wins over push/pop)
//   head       - head entry (undefined when count == 0)
//   count      - number of valid entries, 0..DEPTH
// The producer guarantees no push while full.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ROM_AWIDTH_DEF + IWIDTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC, issues reads to a
// synchronous ROM (data one cycle after rom_rd), buffers words in a
// prefetch queue and hands {instr, pc} to decode via valid/ready.
// Redirects flush the queue and kill any in-flight read.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   rom_rd/rom_raddr         - ROM read strobe and word address
//   rom_rdata                - ROM data, valid the cycle after rom_rd
//   redirect/redirect_pc     - flush and restart fetch at redirect_pc
//   o_valid/i_ready          - output handshake
//   o_instr/o_pc/o_pc_plus1  - head instruction, its address, address+1
// Optional: define FETCH_PERF_EN to add o_fetch_cnt (pops) and
// o_bubble_cnt (cycles with i_ready && !o_valid), 16-bit saturating.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ROM_AWIDTH = ROM_AWIDTH_DEF,
  parameter int IWIDTH     = IWIDTH_DEF,
  parameter int QDEPTH     = 4,
  parameter logic [ROM_AWIDTH-1:0] RESET_PC = ROM_AWIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rom_rd,
  output logic [ROM_AWIDTH-1:0] rom_raddr,
  input  logic [IWIDTH-1:0]     rom_rdata,
  input  logic                  redirect,
  input  logic [ROM_AWIDTH-1:0] redirect_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [IWIDTH-1:0]     o_instr,
  output logic [ROM_AWIDTH-1:0] o_pc,
  output logic [ROM_AWIDTH-1:0] o_pc_plus1
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]           o_fetch_cnt,
  output logic [15:0]           o_bubble_cnt
`endif
);
  localparam int EW = ROM_AWIDTH + IWIDTH;
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ROM_AWIDTH-1:0] fetch_pc;
  logic [ROM_AWIDTH-1:0] pending_pc;
  logic                  pending;
  logic                  redirect_q;
  logic                  pop;
  logic                  push;
  logic [CW-1:0]         count;
  logic [EW-1:0]         head;
  logic [CW:0]           credit;

  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready;

  // Slots committed after this edge: queued + in flight - leaving now.
  // Issuing only while this is below QDEPTH makes overflow impossible.
  always_comb begin
    credit = {1'b0, count} + (CW+1)'(pending) - (CW+1)'(pop);
    rom_rd = !rst && !redirect_q && (credit < (CW+1)'(QDEPTH));
  end

  assign rom_raddr = fetch_pc;

  // A redirect at this edge discards the word arriving now, and clearing
  // pending discards the word requested this cycle.
  assign push = pending && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= '0;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= redirect;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        pending  <= 1'b0;
      end else begin
        pending <= rom_rd;
        if (rom_rd) begin
          fetch_pc   <= fetch_pc + 1'b1;
          pending_pc <= fetch_pc;
        end
      end
    end
  end

  fetch_queue #(.DEPTH(QDEPTH), .W(EW)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pending_pc, rom_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  // Mask the head so an empty queue presents zeros.
  assign o_pc       = o_valid ? head[EW-1:IWIDTH] : '0;
  assign o_instr    = o_valid ? head[IWIDTH-1:0]  : '0;
  assign o_pc_plus1 = o_pc + 1'b1;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_fetch_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (pop && o_fetch_cnt != 16'hFFFF)
        o_fetch_cnt <= o_fetch_cnt + 1'b1;
      if (i_ready && !o_valid && o_bubble_cnt != 16'hFFFF)
        o_bubble_cnt <= o_bubble_cnt + 1'b1;
    end
  end
`endif
endmodule
